pe_stream_loader: RTL and testbench

Sequencer that loads one PE pass from the global SRAM into the PE's filter and ifmap circular buffers. It streams a filter row, then `num_rows` ifmap rows, and tags every ifmap word with start/end-of-row flags in the 18-bit `{start, end, data}` format the PE input buffer expects. Writes are throttled by each buffer's `ready`. It sits between the global buffer SRAM and the `cb_filter`/`cb_ifmap` buffers that feed `toplevel`.

---
 rtl/pe_stream_loader.sv | 156 +++++++++++++++
 tb/tb_pe_stream_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_stream_loader.sv
// rtl/pe_stream_loader.sv - loads a filter row then ifmap rows from SRAM into PE buffers
// One read in flight at most; a 1-entry skid register absorbs a word whose target stalls.
module pe_stream_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] filter_base,
  input  logic [ADDR_WIDTH-1:0] ifmap_base,
  input  logic [LEN_WIDTH-1:0]  filter_len,
  input  logic [LEN_WIDTH-1:0]  row_len,
  input  logic [LEN_WIDTH-1:0]  num_rows,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  filt_ready,
  output logic                  filt_wr_en,
  output logic [DATA_WIDTH-1:0] filt_wdata,
  input  logic                  ifmap_ready,
  output logic                  ifmap_wr_en,
  output logic [DATA_WIDTH+1:0] ifmap_wdata,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {S_IDLE, S_FILTER, S_IFMAP, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  filter_len_q, row_len_q, num_rows_q;
  logic [LEN_WIDTH-1:0]  filt_cnt_q, col_q, row_q;
  logic [ADDR_WIDTH-1:0] filt_addr_q, ifmap_addr_q;
  logic                  infl_q, infl_tgt_q;
  logic [1:0]            infl_flags_q;
  logic                  skid_q, skid_tgt_q;
  logic [1:0]            skid_flags_q;
  logic [DATA_WIDTH-1:0] skid_data_q;

  logic ret_ready, skid_ready, skid_wr, direct_wr, ret_blocked, phase_ready, issue;
  logic in_ifmap, last_filt, col_last, row_last, ifmap_empty;
  logic wr_en, wr_tgt;
  logic [1:0] wr_flags;
  logic [DATA_WIDTH-1:0] wr_data;

  assign in_ifmap    = (state_q == S_IFMAP);
  assign ret_ready   = infl_tgt_q ? ifmap_ready : filt_ready;
  assign skid_ready  = skid_tgt_q ? ifmap_ready : filt_ready;
  assign skid_wr     = skid_q && skid_ready;
  assign direct_wr   = infl_q && ret_ready;
  assign ret_blocked = infl_q && !ret_ready;
  assign phase_ready = in_ifmap ? ifmap_ready : filt_ready;
  // A skid being emptied this cycle frees the slot for the word issued now.
  assign issue = ((state_q == S_FILTER) || in_ifmap) && phase_ready &&
                 (!skid_q || skid_wr) && !ret_blocked;

  assign last_filt   = (filt_cnt_q == filter_len_q - 1'b1);
  assign col_last    = (col_q == row_len_q - 1'b1);
  assign row_last    = (row_q == num_rows_q - 1'b1);
  assign ifmap_empty = (row_len_q == '0) || (num_rows_q == '0);

  // Skid and a direct return never coincide: a blocked return suppresses issue.
  assign wr_en    = skid_wr || direct_wr;
  assign wr_tgt   = skid_q ? skid_tgt_q : infl_tgt_q;
  assign wr_flags = skid_q ? skid_flags_q : infl_flags_q;
  assign wr_data  = skid_q ? skid_data_q : mem_rdata;

  always_comb begin
    state_d     = state_q;
    mem_rd_en   = issue;
    mem_addr    = '0;
    filt_wr_en  = wr_en && !wr_tgt;
    filt_wdata  = '0;
    ifmap_wr_en = wr_en && wr_tgt;
    ifmap_wdata = '0;
    busy        = (state_q == S_FILTER) || in_ifmap || (state_q == S_DRAIN);
    done        = (state_q == S_DONE);
    if (issue) mem_addr = in_ifmap ? ifmap_addr_q : filt_addr_q;
    if (filt_wr_en) filt_wdata = wr_data;
    if (ifmap_wr_en) ifmap_wdata = {wr_flags, wr_data};
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (filter_len != '0) state_d = S_FILTER;
          else if ((row_len == '0) || (num_rows == '0)) state_d = S_DRAIN;
          else state_d = S_IFMAP;
        end
      end
      S_FILTER: if (issue && last_filt) state_d = ifmap_empty ? S_DRAIN : S_IFMAP;
      S_IFMAP:  if (issue && col_last && row_last) state_d = S_DRAIN;
      S_DRAIN:  if ((!skid_q || skid_wr) && (!infl_q || direct_wr)) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      filter_len_q <= '0;
      row_len_q    <= '0;
      num_rows_q   <= '0;
      filt_cnt_q   <= '0;
      col_q        <= '0;
      row_q        <= '0;
      filt_addr_q  <= '0;
      ifmap_addr_q <= '0;
      infl_q       <= 1'b0;
      infl_tgt_q   <= 1'b0;
      infl_flags_q <= '0;
      skid_q       <= 1'b0;
      skid_tgt_q   <= 1'b0;
      skid_flags_q <= '0;
      skid_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        filter_len_q <= filter_len;
        row_len_q    <= row_len;
        num_rows_q   <= num_rows;
        filt_addr_q  <= filter_base;
        ifmap_addr_q <= ifmap_base;
        filt_cnt_q   <= '0;
        col_q        <= '0;
        row_q        <= '0;
      end
      if (issue) begin
        if (in_ifmap) begin
          ifmap_addr_q <= ifmap_addr_q + 1'b1;
          if (col_last) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end else begin
          filt_addr_q <= filt_addr_q + 1'b1;
          filt_cnt_q  <= filt_cnt_q + 1'b1;
        end
      end
      infl_q       <= issue;
      infl_tgt_q   <= in_ifmap;
      infl_flags_q <= (issue && in_ifmap) ? {col_q == '0, col_last} : 2'b00;
      if (ret_blocked) begin
        skid_q       <= 1'b1;
        skid_tgt_q   <= infl_tgt_q;
        skid_flags_q <= infl_flags_q;
        skid_data_q  <= mem_rdata;
      end else if (skid_wr) begin
        skid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_stream_loader.sv
// tb/tb_pe_stream_loader.sv - directed scoreboard bench for pe_stream_loader
module tb_pe_stream_loader;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] filter_base, ifmap_base;
  logic [LW-1:0] filter_len, row_len, num_rows;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          filt_ready, filt_wr_en;
  logic [DW-1:0] filt_wdata;
  logic          ifmap_ready, ifmap_wr_en;
  logic [DW+1:0] ifmap_wdata;
  logic          busy, done;

  pe_stream_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .filter_base(filter_base), .ifmap_base(ifmap_base),
    .filter_len(filter_len), .row_len(row_len), .num_rows(num_rows),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .filt_ready(filt_ready), .filt_wr_en(filt_wr_en), .filt_wdata(filt_wdata),
    .ifmap_ready(ifmap_ready), .ifmap_wr_en(ifmap_wr_en), .ifmap_wdata(ifmap_wdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int filt_first, filt_last, ifm_first, ifm_last, nfilt, nifm, nreads;

  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] exp_filt_q[$];
  logic [DW+1:0] exp_ifm_q[$];
  logic [AW-1:0] exp_addr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: data one cycle after the strobe, noise otherwise
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : DW'($urandom);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      automatic int rel = cyc - start_cyc;
      if (mem_rd_en) begin
        nreads++;
        chk("read_expected", exp_addr_q.size() != 0, 1);
        if (exp_addr_q.size() != 0) chk("read_addr", mem_addr, exp_addr_q.pop_front());
      end
      if (filt_wr_en) begin
        if (nfilt == 0) filt_first = rel;
        filt_last = rel;
        nfilt++;
        chk("filt_wr_ready", filt_ready, 1);
        chk("filt_expected", exp_filt_q.size() != 0, 1);
        if (exp_filt_q.size() != 0) chk("filt_wdata", filt_wdata, exp_filt_q.pop_front());
      end
      if (ifmap_wr_en) begin
        if (nifm == 0) ifm_first = rel;
        ifm_last = rel;
        nifm++;
        chk("ifmap_wr_ready", ifmap_ready, 1);
        chk("ifmap_expected", exp_ifm_q.size() != 0, 1);
        if (exp_ifm_q.size() != 0) chk("ifmap_wdata", ifmap_wdata, exp_ifm_q.pop_front());
      end
      if (done) chk("done_not_busy", busy, 0);
    end
  end

  task automatic launch(input int fl, input int rl, input int nr, input int fb, input int ib);
    logic [AW-1:0] a;
    for (int i = 0; i < fl; i++) begin
      a = AW'(fb + i);
      exp_addr_q.push_back(a);
      exp_filt_q.push_back(mem[a]);
    end
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < rl; c++) begin
        a = AW'(ib + r * rl + c);
        exp_addr_q.push_back(a);
        exp_ifm_q.push_back({c == 0, c == rl - 1, mem[a]});
      end
    nfilt = 0; nifm = 0; nreads = 0;
    filt_first = -1; filt_last = -1; ifm_first = -1; ifm_last = -1;
    start = 1'b1;
    filter_len = LW'(fl); row_len = LW'(rl); num_rows = LW'(nr);
    filter_base = AW'(fb); ifmap_base = AW'(ib);
    @(posedge clk);
    #1;
    start_cyc = cyc - 1;
    start = 1'b0;
    filter_len = LW'($urandom); row_len = LW'($urandom); num_rows = LW'($urandom);
    filter_base = AW'($urandom); ifmap_base = AW'($urandom);
  endtask

  task automatic run_wait(input int lo, input int hi, input int poke, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < 200 && done_cyc < 0; i++) begin
      automatic int rel = cyc - start_cyc;
      ifmap_ready = !(rel >= lo && rel <= hi);
      start = (rel == poke);
      @(negedge clk);
      if (done) done_cyc = cyc - start_cyc;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    ifmap_ready = 1'b1;
    chk("done_seen", done_cyc >= 0, 1);
    chk("filt_q_empty", exp_filt_q.size(), 0);
    chk("ifmap_q_empty", exp_ifm_q.size(), 0);
    chk("addr_q_empty", exp_addr_q.size(), 0);
  endtask

  task automatic load_scenario1_mem();
    mem[100] = -16'sd129; mem[101] = 16'd3; mem[102] = 16'd41;
    mem[200] = 16'd14;    mem[205] = -16'sd80;
    mem[206] = 16'd122;   mem[211] = 16'd147;
  endtask

  initial begin
    int dc;
    rst = 1'b1; start = 1'b0;
    filter_base = '0; ifmap_base = '0; filter_len = '0; row_len = '0; num_rows = '0;
    filt_ready = 1'b1; ifmap_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
    load_scenario1_mem();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_filt_wr_en", filt_wr_en, 0);
    chk("rst_filt_wdata", filt_wdata, 0);
    chk("rst_ifmap_wr_en", ifmap_wr_en, 0);
    chk("rst_ifmap_wdata", ifmap_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Baseline run, both buffers always ready
    launch(3, 6, 2, 100, 200);
    chk("s1_busy_c1", busy, 1);
    chk("s1_rd_c1", mem_rd_en, 1);
    run_wait(-1, -1, -1, dc);
    chk("s1_done_cycle", dc, 17);
    chk("s1_filt_first", filt_first, 2);
    chk("s1_filt_last", filt_last, 4);
    chk("s1_ifm_first", ifm_first, 5);
    chk("s1_ifm_last", ifm_last, 16);
    chk("s1_nifm", nifm, 12);
    repeat (3) @(posedge clk);
    #1;

    // Ifmap buffer stalls for four cycles mid-row
    launch(3, 6, 2, 100, 200);
    run_wait(6, 9, -1, dc);
    chk("s2_done_cycle", dc, 21);
    chk("s2_nifm", nifm, 12);
    chk("s2_nreads", nreads, 15);
    repeat (3) @(posedge clk);
    #1;

    // Single-word rows carry both flags
    launch(2, 1, 3, 300, 400);
    run_wait(-1, -1, -1, dc);
    chk("s3_done_cycle", dc, 7);
    chk("s3_nifm", nifm, 3);
    repeat (3) @(posedge clk);
    #1;

    // Empty configuration
    launch(0, 5, 0, 0, 0);
    chk("s4_busy_c1", busy, 1);
    run_wait(-1, -1, -1, dc);
    chk("s4_done_cycle", dc, 2);
    chk("s4_nreads", nreads, 0);
    repeat (3) @(posedge clk);
    #1;

    // Start pulse while busy must be ignored
    launch(3, 6, 2, 100, 200);
    run_wait(-1, -1, 8, dc);
    chk("s5_done_cycle", dc, 17);
    repeat (4) @(posedge clk);
    #1;
    chk("s5_idle_busy", busy, 0);
    chk("s5_nreads", nreads, 15);

    // Reset mid-run, then a clean rerun
    launch(3, 6, 2, 100, 200);
    repeat (5) @(posedge clk);
    #1;
    chk("s6_at_cycle6", cyc - start_cyc, 6);
    rst = 1'b1;
    #1;
    chk("s6_mem_rd_en", mem_rd_en, 0);
    chk("s6_mem_addr", mem_addr, 0);
    chk("s6_filt_wr_en", filt_wr_en, 0);
    chk("s6_ifmap_wr_en", ifmap_wr_en, 0);
    chk("s6_ifmap_wdata", ifmap_wdata, 0);
    chk("s6_busy", busy, 0);
    chk("s6_done", done, 0);
    exp_filt_q.delete(); exp_ifm_q.delete(); exp_addr_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    launch(3, 6, 2, 100, 200);
    run_wait(-1, -1, -1, dc);
    chk("s6_rerun_done", dc, 17);
    chk("s6_rerun_nifm", nifm, 12);
    repeat (3) @(posedge clk);
    #1;

    // Address wrap at the top of SRAM
    launch(0, 4, 1, 0, 1022);
    run_wait(-1, -1, -1, dc);
    chk("s7_done_cycle", dc, 6);
    chk("s7_nreads", nreads, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
